// File: rtl/t_deserializer.sv
// Serial-to-parallel frame receiver: S1, S2, N data bits (LSB first), even parity.
// Decoded words are published only when a complete frame passes the parity check.
module t_deserializer #(
  parameter int N = 98
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin_valid,
  input  logic         sin_data,
  input  logic         sin_sync,
  output logic [N-1:0] IN,
  output logic         S1,
  output logic         S2,
  output logic         out_valid,
  output logic         frame_err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, MODE, DATA, PARITY} t_state;

  t_state         r_state, w_state;
  logic [CW-1:0]  r_cnt, w_cnt;
  logic           r_par, w_par;
  logic [N-1:0]   r_shadow, w_shadow;
  logic           r_sh_s1, w_sh_s1;
  logic           r_sh_s2, w_sh_s2;
  logic [N-1:0]   r_in, w_in;
  logic           r_s1, w_s1;
  logic           r_s2, w_s2;
  logic           r_out_valid, w_out_valid;
  logic           r_frame_err, w_frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_par       <= 1'b0;
      r_shadow    <= '0;
      r_sh_s1     <= 1'b0;
      r_sh_s2     <= 1'b0;
      r_in        <= '0;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_par       <= w_par;
      r_shadow    <= w_shadow;
      r_sh_s1     <= w_sh_s1;
      r_sh_s2     <= w_sh_s2;
      r_in        <= w_in;
      r_s1        <= w_s1;
      r_s2        <= w_s2;
      r_out_valid <= w_out_valid;
      r_frame_err <= w_frame_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_par       = r_par;
    w_shadow    = r_shadow;
    w_sh_s1     = r_sh_s1;
    w_sh_s2     = r_sh_s2;
    w_in        = r_in;
    w_s1        = r_s1;
    w_s2        = r_s2;
    w_out_valid = 1'b0;
    w_frame_err = 1'b0;

    if (sin_valid) begin
      if (sin_sync) begin
        // A sync bit always opens a new frame; any frame in flight is aborted.
        w_frame_err = (r_state != IDLE);
        w_sh_s1     = sin_data;
        w_par       = sin_data;
        w_state     = MODE;
      end else begin
        case (r_state)
          MODE: begin
            w_sh_s2 = sin_data;
            w_par   = r_par ^ sin_data;
            w_cnt   = '0;
            w_state = DATA;
          end
          DATA: begin
            w_shadow[r_cnt] = sin_data;
            w_par           = r_par ^ sin_data;
            if (r_cnt == LAST) begin
              w_state = PARITY;
            end else begin
              w_cnt = r_cnt + 1'b1;
            end
          end
          PARITY: begin
            if ((r_par ^ sin_data) == 1'b0) begin
              w_in        = r_shadow;
              w_s1        = r_sh_s1;
              w_s2        = r_sh_s2;
              w_out_valid = 1'b1;
            end else begin
              w_frame_err = 1'b1;
            end
            w_par   = 1'b0;
            w_state = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign IN        = r_in;
  assign S1        = r_s1;
  assign S2        = r_s2;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;

endmodule
